// File: rtl/btb_update_unit.sv
// rtl/btb_update_unit.sv - BTB write-side unit: mispredict detection, fetch redirect, coalescing update queue, perf counters
module btb_update_unit #(
    parameter int INDEX_WIDTH = 12,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ex_valid_i,
    output logic                    ex_ready_o,
    input  logic [31:0]             ex_pc_i,
    input  logic                    ex_is_branch_i,
    input  logic                    ex_taken_i,
    input  logic [31:0]             ex_target_i,
    input  logic                    ex_pred_taken_i,
    input  logic [31:0]             ex_pred_target_i,
    output logic                    mispredict_o,
    output logic [31:0]             redirect_pc_o,
    output logic                    btb_wren_o,
    input  logic                    btb_wr_ready_i,
    output logic [INDEX_WIDTH-1:0]  btb_wr_index_o,
    output logic [29-INDEX_WIDTH:0] btb_wr_tag_o,
    output logic [31:0]             btb_wr_target_o,
    output logic [CNT_WIDTH-1:0]    br_count_o,
    output logic [CNT_WIDTH-1:0]    mispred_count_o
);
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
    localparam int PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int CNT_QW    = PTR_W + 1;

    logic [INDEX_WIDTH-1:0] idx_q [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]   tag_q [QUEUE_DEPTH];
    logic [31:0]            tgt_q [QUEUE_DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_QW-1:0]    count_q, count_d;
    logic                 mispredict_q, mispredict_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

    logic                   full, empty, accept, mispred, update, coalesce, push, pop;
    logic [PTR_W-1:0]       tail_ptr;
    logic [INDEX_WIDTH-1:0] new_idx;
    logic [TAG_WIDTH-1:0]   new_tag;

    assign full       = (count_q == CNT_QW'(QUEUE_DEPTH));
    assign empty      = (count_q == '0);
    assign ex_ready_o = !full;
    assign accept     = ex_valid_i & ex_ready_o;

    assign mispred = (ex_is_branch_i & (ex_taken_i != ex_pred_taken_i))
                   | (ex_is_branch_i & ex_taken_i & ex_pred_taken_i & (ex_target_i != ex_pred_target_i))
                   | (!ex_is_branch_i & ex_pred_taken_i);
    assign update  = accept & ex_is_branch_i & ex_taken_i
                   & (!ex_pred_taken_i | (ex_target_i != ex_pred_target_i));

    assign new_idx  = ex_pc_i[INDEX_WIDTH+1:2];
    assign new_tag  = ex_pc_i[31:INDEX_WIDTH+2];
    assign tail_ptr = wr_ptr_q - 1'b1;

    assign btb_wren_o      = !empty & btb_wr_ready_i;
    assign pop             = btb_wren_o;
    assign btb_wr_index_o  = idx_q[rd_ptr_q];
    assign btb_wr_tag_o    = tag_q[rd_ptr_q];
    assign btb_wr_target_o = tgt_q[rd_ptr_q];

    // Coalesce into the tail only if it survives this cycle (not the entry being popped).
    assign coalesce = update & !empty & (idx_q[tail_ptr] == new_idx)
                    & !(pop & (count_q == CNT_QW'(1)));
    assign push     = update & !coalesce;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        mispredict_d  = accept & mispred;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        mp_cnt_d      = mp_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (accept && mispred)
            redirect_pc_d = (ex_is_branch_i & ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
        if (accept && ex_is_branch_i && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 1'b1;
        if (accept && mispred && (mp_cnt_q != '1))        mp_cnt_d = mp_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mp_cnt_q      <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            mp_cnt_q      <= mp_cnt_d;
        end
    end

    // Entry storage needs no reset: count_q gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            idx_q[wr_ptr_q] <= new_idx;
            tag_q[wr_ptr_q] <= new_tag;
            tgt_q[wr_ptr_q] <= ex_target_i;
        end else if (coalesce) begin
            tag_q[tail_ptr] <= new_tag;
            tgt_q[tail_ptr] <= ex_target_i;
        end
    end

    assign mispredict_o    = mispredict_q;
    assign redirect_pc_o   = redirect_pc_q;
    assign br_count_o      = br_cnt_q;
    assign mispred_count_o = mp_cnt_q;
endmodule
